// File: rtl/rr_arbiter3.sv
// Three-requester round-robin arbiter with a bounded hold time.
// Registered one-hot grant; an owner past MAX_HOLD cycles is pre-empted.
module rr_arbiter3 #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       req,
  output logic [2:0]       grant,
  output logic             busy,
  output logic             any_req,
  output logic [CNT_W-1:0] hold_cnt,
  output logic             timeout
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state_q, state_d;
  logic [2:0]       grant_q, grant_d;
  logic [1:0]       last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             busy_q, busy_d;
  logic [1:0]       own;

  // Search starts just after ptr and wraps back to ptr itself.
  function automatic logic [2:0] pick_fn(
    input logic [1:0] ptr,
    input logic [2:0] r
  );
    logic [2:0] g;
    int         idx;
    g = 3'b000;
    for (int k = 1; k <= 3; k++) begin
      idx = (int'(ptr) + k) % 3;
      if (r[idx] && g == 3'b000)
        g[idx] = 1'b1;
    end
    return g;
  endfunction

  assign any_req  = |req;
  assign grant    = grant_q;
  assign busy     = busy_q;
  assign hold_cnt = cnt_q;
  assign timeout  = timeout_q;

  // Index of the current owner, decoded from the one-hot grant.
  always_comb begin
    own = 2'd0;
    unique case (1'b1)
      grant_q[0]: own = 2'd0;
      grant_q[1]: own = 2'd1;
      grant_q[2]: own = 2'd2;
      default:    own = 2'd0;
    endcase
  end

  // Next-state: grant from idle, release/hand-off, pre-empt or hold.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d = pick_fn(last_q, req);
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!req[own]) begin
          last_d  = own;
          cnt_d   = '0;
          grant_d = pick_fn(own, req);
          state_d = (|pick_fn(own, req)) ? GRANT : IDLE;
        end else if (cnt_q == HOLD_LAST) begin
          last_d    = own;
          timeout_d = 1'b1;
          cnt_d     = '0;
          grant_d   = pick_fn(own, req);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 3'b000;
        cnt_d   = '0;
      end
    endcase
    busy_d = |grant_d;
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= 3'b000;
      last_q    <= 2'd2;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
    end
  end

endmodule

// File: tb/tb_rr_arbiter3.sv
// Directed bench for rr_arbiter3 with MAX_HOLD=8.
// Expected values are hand-computed per step.
module tb_rr_arbiter3;

  logic       clk;
  logic       rst_n;
  logic [2:0] req;
  logic [2:0] grant;
  logic       busy;
  logic       any_req;
  logic [3:0] hold_cnt;
  logic       timeout;

  int total;
  int bad;

  rr_arbiter3 #(
    .MAX_HOLD(8),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .grant(grant),
    .busy(busy),
    .any_req(any_req),
    .hold_cnt(hold_cnt),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock edge, then sample 1 ns later and check invariants.
  task automatic step();
    @(posedge clk);
    #1;
    chk("onehot0", 32'($onehot0(grant)), 32'd1);
    if (grant == 3'b000)
      chk("idle_cnt", 32'(hold_cnt), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 3'b000;
    #3;
    rst_n = 1'b1;
    #1;
  endtask

  // Expect grant/busy/hold/timeout after an edge.
  task automatic expect_st(
    input string      tag,
    input logic [2:0] g,
    input int         h,
    input logic       t
  );
    chk({tag, "_grant"}, 32'(grant), 32'(g));
    chk({tag, "_busy"}, 32'(busy), 32'(g != 3'b000));
    chk({tag, "_hold"}, 32'(hold_cnt), 32'(h));
    chk({tag, "_tmo"}, 32'(timeout), 32'(t));
  endtask

  logic [2:0] seq [4];

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    req   = 3'b000;
    #2;
    expect_st("reset", 3'b000, 0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single requester, then drop.
    req = 3'b001;
    #1;
    chk("any_req_comb", 32'(any_req), 32'd1);
    step();
    expect_st("single_c1", 3'b001, 0, 1'b0);
    step();
    expect_st("single_c2", 3'b001, 1, 1'b0);
    step();
    expect_st("single_c3", 3'b001, 2, 1'b0);
    req = 3'b000;
    #1;
    chk("any_req_low", 32'(any_req), 32'd0);
    step();
    expect_st("single_drop", 3'b000, 0, 1'b0);

    // Full rotation with all requesting.
    do_reset();
    seq[0] = 3'b001;
    seq[1] = 3'b010;
    seq[2] = 3'b100;
    seq[3] = 3'b001;
    req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 8; c++) begin
        step();
        expect_st($sformatf("rr_%0d_%0d", k, c), seq[k], c,
                  (c == 0) && (k != 0));
      end
    end

    // Skip non-requester: owner 0 releases, 2 pending.
    do_reset();
    req = 3'b101;
    step();
    expect_st("skip_c1", 3'b001, 0, 1'b0);
    step();
    expect_st("skip_c2", 3'b001, 1, 1'b0);
    req = 3'b100;
    step();
    expect_st("skip_hand", 3'b100, 0, 1'b0);

    // Sole requester overrun.
    do_reset();
    req = 3'b010;
    for (int n = 1; n <= 20; n++) begin
      step();
      expect_st($sformatf("sole_%0d", n), 3'b010, (n - 1) % 8,
                (n > 1) && ((n - 1) % 8 == 0));
    end

    // Async reset mid-grant.
    do_reset();
    req = 3'b100;
    step();
    expect_st("ar_g", 3'b100, 0, 1'b0);
    step();
    expect_st("ar_g2", 3'b100, 1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    expect_st("ar_clr", 3'b000, 0, 1'b0);
    req = 3'b110;
    #1;
    rst_n = 1'b1;
    step();
    expect_st("ar_rel", 3'b010, 0, 1'b0);
    step();
    expect_st("ar_rel2", 3'b010, 1, 1'b0);

    // Owner 1 drops as requester 0 rises.
    req = 3'b001;
    step();
    expect_st("simul", 3'b001, 0, 1'b0);
    step();
    expect_st("simul2", 3'b001, 1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_arbiter3.md
Name: rr_arbiter3

Overview:
- Three-requester round-robin arbiter with a bounded hold time, for a single shared resource.
- Three request lines feed a 3-input OR that produces the "any request" indication. The arbiter serialises those requesters onto the resource with a registered one-hot grant.
- Sits between three masters (e.g. ALU or bus users) and the shared unit. A starvation guard pre-empts any owner that holds the grant past MAX_HOLD cycles.

Parameters:
- MAX_HOLD, 8, maximum consecutive cycles one owner may hold the grant while others wait or it re-requests; legal range 2..2^CNT_W.
- CNT_W, 4, width of the hold counter.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  3  request lines; req[i] high means requester i wants the resource. Level-sensitive, held until done.
- grant  output  3  registered one-hot grant (000 when idle).
- busy  output  1  registered; equals OR of grant bits.
- any_req  output  1  combinational OR of req[2:0].
- hold_cnt  output  CNT_W  registered cycles-held count of the current owner.
- timeout  output  1  registered one-cycle pulse when the owner is pre-empted.

Behaviour:
- Reset (rst_n=0, asynchronous, no clock needed):
  - grant=000, busy=0, hold_cnt=0, timeout=0, state=IDLE.
  - Last-owner pointer last=2, so requester 0 has first priority.
- Pick order: the search starts at (last+1) mod 3 and wraps through all three indices, including last itself. The first index with req=1 wins.
- State IDLE:
  - If any_req=1, at the next edge grant<=onehot(pick), hold_cnt<=0, state<=GRANT.
  - Otherwise stay idle; outputs stay 0.
  - Latency from request to grant is 1 cycle.
- State GRANT, owner i = index of the set grant bit. At each edge, in priority order:
  - Release: req[i]=0. Set last<=i, hold_cnt<=0, timeout<=0. If another req is pending, grant<=onehot(pick) and stay in GRANT (hand-off with no bubble). Else grant<=000, state<=IDLE.
  - Pre-empt: req[i]=1 and hold_cnt==MAX_HOLD-1. Set last<=i, timeout<=1, hold_cnt<=0, grant<=onehot(pick). If i is the only requester, pick returns i: it is re-granted and timeout still pulses.
  - Hold: otherwise hold_cnt<=hold_cnt+1, grant unchanged, timeout<=0.
- Hold limit: an owner holds the grant for at most MAX_HOLD consecutive cycles (hold_cnt 0..MAX_HOLD-1).
- timeout is high only in the single cycle following a pre-empt edge.
- Requests arriving or dropping in the same cycle as a release or pre-empt are sampled at that edge; there is no extra buffering.
- A request dropped before it is granted is simply lost. Requesters must hold req until they see grant.
- Invariants:
  - grant is always one-hot or zero, never multi-hot.
  - busy==|grant.
  - hold_cnt==0 whenever grant==000.
- Reset mid-grant: immediate async clear to reset values; the pointer returns to last=2.
- X on req is not defined; the bench must drive known values.

Test Plan:
- Reset then req=001: grant=001 after 1 edge, busy=1, any_req=1 immediately. Drop req at cycle 3: next edge grant=000, busy=0, hold_cnt=0.
- Round-robin with req=111 held, MAX_HOLD=8:
  - grant=001 for 8 cycles (hold_cnt 0..7), then 010 with timeout=1 for one cycle.
  - Then 8 cycles of 010, then 100, then 001; the rotation repeats.
- Skip non-requesters: last owner 0 releases while req=101. Hand-off the same edge: grant 001 -> 100, no idle cycle, timeout=0.
- Sole requester overrun: req=010 held for 20 cycles (MAX_HOLD=8). grant stays 010 throughout; timeout pulses at cycles 9 and 17 after the first grant; hold_cnt returns to 0 at each pulse.
- Async reset mid-grant: assert rst_n=0 between clock edges while grant=100. grant, busy and hold_cnt go to 0 with no clock edge. Release reset with req=110: next edge grant=010 (pointer reset to 2).
- Simultaneous release and new request: owner 1 drops req in the same cycle req[0] rises (req=001). Next edge grant=001, hold_cnt=0; grant never shows two bits set.
